// File: rtl/dk_anim_ctrl_if.sv
// Signal bundle between the Donkey Kong animation sequencer and the VGA/drawer/barrel side.
// The sequencer takes the master view and the surrounding logic takes the slave view.
interface dk_anim_ctrl_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       run;
  logic       barrel_ack;
  logic [9:0] curr_h;
  logic [9:0] curr_v;
  logic [1:0] sprite_selec;
  logic       barrel_req;
  logic       frame_tick;

  modport master (
    input  hcount, vcount, run, barrel_ack,
    output curr_h, curr_v, sprite_selec, barrel_req, frame_tick
  );

  modport slave (
    output hcount, vcount, run, barrel_ack,
    input  curr_h, curr_v, sprite_selec, barrel_req, frame_tick
  );
endinterface

// File: rtl/dk_anim_ctrl.sv
// Per-frame Donkey Kong animation sequencer: idle, chest-beat with bounce, grab, then a
// barrel throw request held until the spawner acknowledges it.
module dk_anim_ctrl #(
  parameter int DK_H        = 150,
  parameter int DK_V        = 390,
  parameter int FRAME_LINE  = 480,
  parameter int IDLE_FRAMES = 60,
  parameter int STEP_FRAMES = 8,
  parameter int CHEST_BEATS = 4,
  parameter int GRAB_FRAMES = 16,
  parameter int BOUNCE      = 2
) (
  input logic           clk,
  input logic           reset,
  dk_anim_ctrl_if.master bus
);

  localparam int FC_MAX = (IDLE_FRAMES > STEP_FRAMES)
                          ? ((IDLE_FRAMES > GRAB_FRAMES) ? IDLE_FRAMES : GRAB_FRAMES)
                          : ((STEP_FRAMES > GRAB_FRAMES) ? STEP_FRAMES : GRAB_FRAMES);
  localparam int FCW = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;
  localparam int BCW = (CHEST_BEATS > 1) ? $clog2(CHEST_BEATS) : 1;

  localparam logic [FCW-1:0] IDLE_LAST  = FCW'(IDLE_FRAMES - 1);
  localparam logic [FCW-1:0] STEP_LAST  = FCW'(STEP_FRAMES - 1);
  localparam logic [FCW-1:0] GRAB_LAST  = FCW'(GRAB_FRAMES - 1);
  localparam logic [BCW-1:0] BEATS_LAST = BCW'(CHEST_BEATS - 1);

  localparam logic [9:0] H_POS      = 10'(DK_H);
  localparam logic [9:0] V_REST     = 10'(DK_V);
  localparam logic [9:0] V_UP       = 10'(DK_V - BOUNCE);
  localparam logic [9:0] TICK_LINE  = 10'(FRAME_LINE);

  localparam logic [1:0] SPR_STAND  = 2'd0;
  localparam logic [1:0] SPR_BEAT_L = 2'd1;
  localparam logic [1:0] SPR_BEAT_R = 2'd2;
  localparam logic [1:0] SPR_GRAB   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHEST,
    S_GRAB,
    S_THROW
  } state_t;

  state_t         state_q, state_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           cond_prev_q, cond_prev_d;
  logic           frame_tick_q, frame_tick_d;
  logic [9:0]     curr_h_q, curr_h_d;
  logic [9:0]     curr_v_q, curr_v_d;
  logic [1:0]     sprite_q, sprite_d;
  logic           barrel_req_q, barrel_req_d;
  logic           frame_cond;

  always_comb begin
    frame_cond   = (bus.hcount == 10'd0) && (bus.vcount == TICK_LINE);
    cond_prev_d  = frame_cond;
    frame_tick_d = frame_cond && !cond_prev_q;

    state_d = state_q;
    fc_d    = fc_q;
    bc_d    = bc_q;

    if (!bus.run) begin
      state_d = S_IDLE;
      fc_d    = '0;
      bc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_tick_q) begin
            if (fc_q == IDLE_LAST) begin
              state_d = S_CHEST;
              fc_d    = '0;
              bc_d    = '0;
            end else begin
              fc_d = fc_q + 1'b1;
            end
          end
        end
        S_CHEST: begin
          if (frame_tick_q) begin
            if (fc_q == STEP_LAST) begin
              fc_d = '0;
              if (bc_q == BEATS_LAST) begin
                state_d = S_GRAB;
                bc_d    = '0;
              end else begin
                bc_d = bc_q + 1'b1;
              end
            end else begin
              fc_d = fc_q + 1'b1;
            end
          end
        end
        S_GRAB: begin
          if (frame_tick_q) begin
            if (fc_q == GRAB_LAST) begin
              state_d = S_THROW;
              fc_d    = '0;
            end else begin
              fc_d = fc_q + 1'b1;
            end
          end
        end
        S_THROW: begin
          // Frame ticks are not counted here, so an ack that lands with a tick simply wins.
          if (barrel_req_q && bus.barrel_ack) begin
            state_d = S_IDLE;
            fc_d    = '0;
            bc_d    = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          fc_d    = '0;
          bc_d    = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    curr_h_d     = H_POS;
    curr_v_d     = V_REST;
    sprite_d     = SPR_STAND;
    barrel_req_d = 1'b0;
    case (state_d)
      S_CHEST: begin
        sprite_d = bc_d[0] ? SPR_BEAT_R : SPR_BEAT_L;
        curr_v_d = bc_d[0] ? V_UP : V_REST;
      end
      S_GRAB: begin
        sprite_d = SPR_GRAB;
      end
      S_THROW: begin
        sprite_d     = SPR_GRAB;
        barrel_req_d = 1'b1;
      end
      default: begin
        sprite_d = SPR_STAND;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fc_q         <= '0;
      bc_q         <= '0;
      cond_prev_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      curr_h_q     <= H_POS;
      curr_v_q     <= V_REST;
      sprite_q     <= SPR_STAND;
      barrel_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fc_q         <= fc_d;
      bc_q         <= bc_d;
      cond_prev_q  <= cond_prev_d;
      frame_tick_q <= frame_tick_d;
      curr_h_q     <= curr_h_d;
      curr_v_q     <= curr_v_d;
      sprite_q     <= sprite_d;
      barrel_req_q <= barrel_req_d;
    end
  end

  assign bus.curr_h       = curr_h_q;
  assign bus.curr_v       = curr_v_q;
  assign bus.sprite_selec = sprite_q;
  assign bus.barrel_req   = barrel_req_q;
  assign bus.frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_dk_anim_ctrl.sv
// Bench for dk_anim_ctrl: a timeline model (frames counted since the sequence started)
// checked every cycle, plus hand-computed literal expectations for each scenario.
module tb_dk_anim_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dk_anim_ctrl_if bus();

  dk_anim_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int CHEST_T = 60;
  localparam int GRAB_T  = 92;
  localparam int THROW_T = 108;

  int   n_checks = 0;
  int   n_errors = 0;
  int   pulse_cnt = 0;
  logic chk_en = 1'b0;

  // Model state: m_t is the number of frames counted since the sequence started.
  int   m_t = 0;
  logic m_prev = 1'b0;
  logic m_tick = 1'b0;
  logic m_tick_in;
  logic m_cond;

  function automatic int exp_sprite(input int t);
    if (t < CHEST_T) return 0;
    if (t < GRAB_T) return ((((t - CHEST_T) / 8) % 2) == 1) ? 2 : 1;
    return 3;
  endfunction

  function automatic int exp_v(input int t);
    if (t >= CHEST_T && t < GRAB_T && (((t - CHEST_T) / 8) % 2) == 1) return 388;
    return 390;
  endfunction

  function automatic int exp_req(input int t);
    return (t == THROW_T) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    m_tick_in = m_tick;
    if (!reset) begin
      m_t    = 0;
      m_prev = 1'b0;
      m_tick = 1'b0;
    end else begin
      m_cond = (bus.hcount == 10'd0) && (bus.vcount == 10'd480);
      m_tick = m_cond && !m_prev;
      m_prev = m_cond;
      if (!bus.run) m_t = 0;
      else if (m_t == THROW_T) begin
        if (bus.barrel_ack) m_t = 0;
      end else if (m_tick_in) m_t++;
    end
  end

  always @(negedge clk) begin
    if (bus.frame_tick === 1'b1) pulse_cnt++;
    if (chk_en) begin
      checkOutput("cyc_tick",   int'(bus.frame_tick),   int'(m_tick));
      checkOutput("cyc_sprite", int'(bus.sprite_selec), exp_sprite(m_t));
      checkOutput("cyc_v",      int'(bus.curr_v),       exp_v(m_t));
      checkOutput("cyc_h",      int'(bus.curr_h),       150);
      checkOutput("cyc_req",    int'(bus.barrel_req),   exp_req(m_t));
    end
  end

  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic r, input logic a);
    @(posedge clk);
    #1;
    bus.hcount     = h;
    bus.vcount     = v;
    bus.run        = r;
    bus.barrel_ack = a;
  endtask

  task automatic give_ticks(input int n, input logic r);
    repeat (n) begin
      applyStimulus(10'd0, 10'd480, r, 1'b0);
      applyStimulus(10'd5, 10'd0, r, 1'b0);
    end
    applyStimulus(10'd5, 10'd0, r, 1'b0);
  endtask

  task automatic quiet_cycles(input int n, input logic r);
    repeat (n) applyStimulus(10'd5, 10'd0, r, 1'b0);
  endtask

  task automatic check_pose(input string tag, input int spr, input int v, input int req);
    @(negedge clk);
    checkOutput({tag, "_sprite"}, int'(bus.sprite_selec), spr);
    checkOutput({tag, "_v"},      int'(bus.curr_v),       v);
    checkOutput({tag, "_req"},    int'(bus.barrel_req),   req);
  endtask

  int pulses_before;

  initial begin
    bus.hcount     = 10'd5;
    bus.vcount     = 10'd0;
    bus.run        = 1'b0;
    bus.barrel_ack = 1'b0;
    reset          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_h", int'(bus.curr_h), 150);
    checkOutput("rst_tick", int'(bus.frame_tick), 0);
    check_pose("rst", 0, 390, 0);

    $display("[TB] chest-beat entry and bounce");
    give_ticks(60, 1'b1);
    check_pose("beat0", 1, 390, 0);
    give_ticks(8, 1'b1);
    check_pose("beat1", 2, 388, 0);

    $display("[TB] reset mid chest-beat");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check_pose("rst_mid", 0, 390, 0);
    checkOutput("rst_mid_h", int'(bus.curr_h), 150);
    @(posedge clk);
    #1 reset = 1'b1;
    quiet_cycles(2, 1'b1);
    check_pose("post_rst", 0, 390, 0);

    $display("[TB] held frame condition gives one pulse");
    pulses_before = pulse_cnt;
    repeat (3) applyStimulus(10'd0, 10'd480, 1'b0, 1'b0);
    quiet_cycles(3, 1'b0);
    @(negedge clk);
    checkOutput("one_pulse", pulse_cnt - pulses_before, 1);

    $display("[TB] full sequence to throw and ack");
    give_ticks(108, 1'b1);
    check_pose("throw", 3, 390, 1);
    quiet_cycles(100, 1'b1);
    check_pose("throw_hold", 3, 390, 1);
    applyStimulus(10'd5, 10'd0, 1'b1, 1'b1);
    applyStimulus(10'd5, 10'd0, 1'b1, 1'b0);
    check_pose("acked", 0, 390, 0);

    $display("[TB] run dropped during grab");
    give_ticks(95, 1'b1);
    check_pose("grab", 3, 390, 0);
    applyStimulus(10'd5, 10'd0, 1'b0, 1'b0);
    applyStimulus(10'd5, 10'd0, 1'b1, 1'b0);
    check_pose("run_drop", 0, 390, 0);
    give_ticks(59, 1'b1);
    check_pose("drop_59", 0, 390, 0);
    give_ticks(1, 1'b1);
    check_pose("drop_60", 1, 390, 0);

    $display("[TB] ack coincident with frame tick, then ack in idle");
    give_ticks(48, 1'b1);
    check_pose("throw2", 3, 390, 1);
    applyStimulus(10'd0, 10'd480, 1'b1, 1'b0);
    applyStimulus(10'd5, 10'd0, 1'b1, 1'b1);
    applyStimulus(10'd5, 10'd0, 1'b1, 1'b0);
    check_pose("coinc", 0, 390, 0);
    give_ticks(30, 1'b1);
    applyStimulus(10'd5, 10'd0, 1'b1, 1'b1);
    applyStimulus(10'd5, 10'd0, 1'b1, 1'b0);
    check_pose("idle_ack", 0, 390, 0);
    give_ticks(29, 1'b1);
    check_pose("coinc_59", 0, 390, 0);
    give_ticks(1, 1'b1);
    check_pose("coinc_60", 1, 390, 0);

    quiet_cycles(2, 1'b1);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
